// File: rtl/mux_pipe_pkg.sv
// Shared types for the N-way select pipeline stage.
// Occupancy states of the main/skid register pair.
package mux_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/mux_pipe_stage_muxn.sv
// Combinational N-way select with out-of-range zeroing.
// err_o flags a select that names no source.
module muxn #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic [N*WIDTH-1:0] in_i,
    input  logic [SELW-1:0]    sel_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               err_o
);

    always_comb begin
        data_o = '0;
        err_o  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (int'(sel_i) == k) begin
                data_o = in_i[k*WIDTH +: WIDTH];
                err_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_pipe_stage.sv
// N-way select pipeline stage with a 2-entry skid buffer.
// in_ready comes straight from a flop; the skid absorbs the in-flight beat.
module mux_pipe_stage
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_err
);

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;

    logic [WIDTH-1:0]  main_data_q, main_data_d;
    logic [SELW-1:0]   main_sel_q, main_sel_d;
    logic              main_err_q, main_err_d;

    logic [WIDTH-1:0]  skid_data_q, skid_data_d;
    logic [SELW-1:0]   skid_sel_q, skid_sel_d;
    logic              skid_err_q, skid_err_d;

    logic [WIDTH-1:0]  new_data;
    logic              new_err;
    logic              accept;
    logic              deliver;

    muxn #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) u_muxn (
        .in_i   (in_data),
        .sel_i  (in_sel),
        .data_o (new_data),
        .err_o  (new_err)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign deliver   = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_data_d = new_data;
                    main_sel_d  = in_sel;
                    main_err_d  = new_err;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept) begin
                    if (deliver) begin
                        main_data_d = new_data;
                        main_sel_d  = in_sel;
                        main_err_d  = new_err;
                    end else begin
                        skid_data_d = new_data;
                        skid_sel_d  = in_sel;
                        skid_err_d  = new_err;
                        state_d     = ST_FULL;
                    end
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                    main_err_d  = skid_err_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush drops everything, including a beat accepted this cycle.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            main_sel_d  = main_sel_q;
            main_err_d  = main_err_q;
            skid_data_d = skid_data_q;
            skid_sel_d  = skid_sel_q;
            skid_err_d  = skid_err_q;
        end

        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_data = main_data_q;
    assign out_sel  = main_sel_q;
    assign out_err  = main_err_q;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Self-checking bench for mux_pipe_stage: FIFO model plus directed checks.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_mux_pipe_stage;

    localparam int W  = 32;
    localparam int NS = 4;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS*W-1:0] in_data;
    logic [SW-1:0]   in_sel;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_sel;
    logic            out_valid;
    logic            out_ready;
    logic            out_err;

    always #5 clk = ~clk;

    mux_pipe_stage #(
        .WIDTH (W),
        .N     (NS),
        .SELW  (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Model: a plain FIFO of at most two resolved entries.
    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
        logic          e;
    } ent_t;

    ent_t q[$];
    bit   mdl_ok = 0;
    int   n_acc  = 0;

    function automatic ent_t resolve(input logic [NS*W-1:0] d,
                                     input logic [SW-1:0] s);
        ent_t r;
        r.s = s;
        if (int'(s) < NS) begin
            r.d = d[int'(s)*W +: W];
            r.e = 1'b0;
        end else begin
            r.d = '0;
            r.e = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            mdl_ok = 1;
        end else if (mdl_ok) begin
            bit acc, del;
            acc = in_valid && (q.size() < 2);
            del = out_ready && (q.size() > 0);
            if (del) void'(q.pop_front());
            if (acc) q.push_back(resolve(in_data, in_sel));
            if (flush) q.delete();
            else if (acc) n_acc++;
        end
    end

    // Per-cycle compare against the model, plus hold-stability.
    bit            hold_prev = 0;
    logic [W-1:0]  d_prev;
    logic [SW-1:0] s_prev;
    logic          e_prev;

    always @(negedge clk) begin
        if (mdl_ok) begin
            check("in_ready", in_ready, q.size() < 2);
            check("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                check("out_data", out_data, q[0].d);
                check("out_sel", out_sel, q[0].s);
                check("out_err", out_err, q[0].e);
            end
            if (hold_prev) begin
                check("hold_data", out_data, d_prev);
                check("hold_sel", out_sel, s_prev);
                check("hold_err", out_err, e_prev);
            end
            hold_prev = out_valid && !out_ready && !rst && !flush;
            d_prev = out_data;
            s_prev = out_sel;
            e_prev = out_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    initial begin
        int cyc;
        int start;
        rst = 1; in_data = '0; in_sel = '0; in_valid = 0;
        flush = 0; out_ready = 0;
        tick(); tick();
        rst = 0;

        @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_data", out_data, 32'h0);
        check("rst_sel", out_sel, 3'd0);
        check("rst_err", out_err, 1'b0);

        // 1: basic select, one-cycle latency
        tick();
        set_src(0, 32'h1111_1111); set_src(1, 32'h2222_2222);
        set_src(2, 32'hDEAD_BEEF); set_src(3, 32'h4444_4444);
        in_sel = 3'd2; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        @(negedge clk);
        check("t1_valid", out_valid, 1'b1);
        check("t1_data", out_data, 32'hDEAD_BEEF);
        check("t1_sel", out_sel, 3'd2);
        check("t1_err", out_err, 1'b0);
        tick();

        // 2: backpressure fills skid, then drains in order
        out_ready = 0;
        set_src(0, 32'hAAAA_0001); in_sel = 3'd0; in_valid = 1;
        tick();
        set_src(0, 32'hBBBB_0002);
        tick();
        set_src(0, 32'hCCCC_0003);
        @(negedge clk);
        check("t2_full_ready", in_ready, 1'b0);
        check("t2_head_A", out_data, 32'hAAAA_0001);
        tick();
        out_ready = 1;
        tick();
        @(negedge clk);
        check("t2_then_B", out_data, 32'hBBBB_0002);
        tick();
        in_valid = 0;
        @(negedge clk);
        check("t2_then_C", out_data, 32'hCCCC_0003);
        tick();

        // 3: out-of-range select
        out_ready = 0;
        in_sel = 3'd5; in_valid = 1;
        tick();
        in_valid = 0;
        @(negedge clk);
        check("t3_data", out_data, 32'h0);
        check("t3_err", out_err, 1'b1);
        check("t3_sel", out_sel, 3'd5);
        out_ready = 1;
        tick();

        // 4: flush from FULL with a beat offered
        out_ready = 0; in_sel = 3'd1; in_valid = 1;
        set_src(1, 32'h0000_00A1);
        tick();
        set_src(1, 32'h0000_00A2);
        tick();
        set_src(1, 32'h0000_00F1); flush = 1;
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        check("t4_valid", out_valid, 1'b0);
        check("t4_ready", in_ready, 1'b1);
        tick(); tick();
        @(negedge clk);
        check("t4_no_ghost", out_valid, 1'b0);

        // 4b: flush in ONE while a beat is accepted drops it too
        out_ready = 0; in_valid = 1; set_src(1, 32'h0000_00B1);
        tick();
        set_src(1, 32'h0000_00B2); flush = 1;
        tick();
        flush = 0; in_valid = 0;
        @(negedge clk);
        check("t4b_valid", out_valid, 1'b0);
        out_ready = 1;
        tick();

        // 5: random streaming
        start = n_acc;
        cyc = 0;
        while (n_acc < start + 100 && cyc < 3000) begin
            for (int k = 0; k < NS; k++) set_src(k, $urandom);
            in_sel    = SW'($urandom_range(0, 7));
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            tick();
            cyc++;
        end
        in_valid = 0;
        check("t5_beats", n_acc - start >= 100, 1'b1);

        // 6: reset mid-stream with output valid
        out_ready = 0; in_valid = 1; in_sel = 3'd3;
        set_src(3, 32'h3333_3333);
        tick();
        @(negedge clk);
        check("t6_pre_valid", out_valid, 1'b1);
        rst = 1; in_valid = 0;
        tick();
        rst = 0;
        @(negedge clk);
        check("t6_valid", out_valid, 1'b0);
        check("t6_data", out_data, 32'h0);
        check("t6_sel", out_sel, 3'd0);
        check("t6_err", out_err, 1'b0);
        check("t6_ready", in_ready, 1'b1);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
